// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one seven-segment decoder across
// NUM_DIGITS common-anode digits, with frame-synchronous word commit.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BLANK | start of a digit slot: all anodes off, nibble for this slot loaded
// SHOW  | decoded segments driven to the selected anode (unless blanked)
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  input  logic                    lzb_en_i,
  output logic [3:0]              nibble_o,
  input  logic [7:0]              seg_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] display, display_nx;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
  logic                    pending, pending_nx;
  logic [3:0]              nibble_nx;
  logic [7:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   an_nx;

  logic                    frame_start, commit, accept, blank_digit, zero_run;
  logic [NUM_DIGITS-1:0]   lead_zero;

  // lead_zero[i] is set when digits i..NUM_DIGITS-1 of the display are all zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (display[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  assign frame_start  = (state == ST_BLANK) && (cnt == '0) && (idx == '0);
  assign commit       = frame_start && pending;
  assign accept       = load_valid_i && !pending;
  assign blank_digit  = lzb_en_i && (idx != '0) && lead_zero[idx];
  assign load_ready_o = ~pending;
  // Gated by reset so the pulse reads 0 while reset is held.
  assign frame_o      = frame_start & ~rst_i;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    idx_nx     = idx;
    display_nx = commit ? shadow : display;
    shadow_nx  = accept ? load_data_i : shadow;
    pending_nx = accept ? 1'b1 : (commit ? 1'b0 : pending);
    nibble_nx  = nibble_o;
    seg_nx     = 8'hFF;
    an_nx      = '1;

    case (state)
      ST_BLANK: begin
        // Commit-aware fetch so digit 0 of a new frame shows the new word.
        if (cnt == '0) nibble_nx = display_nx[4*idx +: 4];
        if (cnt == BLANK_LAST) state_nx = ST_SHOW;
      end
      ST_SHOW: begin
        if (!blank_digit) begin
          seg_nx = seg_i;
          an_nx  = ~(AN_ONE << idx);
        end
        if (cnt == SLOT_LAST) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
      end
      default: begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      display  <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      nibble_o <= 4'h0;
      seg_o    <= 8'hFF;
      an_o     <= '1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      display  <= display_nx;
      shadow   <= shadow_nx;
      pending  <= pending_nx;
      nibble_o <= nibble_nx;
      seg_o    <= seg_nx;
      an_o     <= an_nx;
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one external SevenSegDecode instance across NUM_DIGITS common-anode digits. It accepts a packed BCD/hex word from the serial-sum datapath through a valid/ready handshake and holds it in a shadow register. The word is committed only at frame boundaries, so the display never tears. The block walks the digits, drives the shared decoder's nibble input, gates the decoded segments with a ghost-suppression blank interval, and optionally blanks leading zeros.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
PRESCALE, 1000, clk_i cycles per digit slot (BLANK + SHOW); must be >= BLANK_CYCLES + 2.
BLANK_CYCLES, 8, cycles at the start of each slot with all anodes off (>= 1).

Ports:
clk_i  input  1  system clock; all state changes on its rising edge.
rst_i  input  1  reset, asynchronous, active-high.
load_valid_i  input  1  load_data_i is valid.
load_ready_o  output  1  block can accept a word; transfer occurs when valid && ready.
load_data_i  input  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (least significant, rightmost).
lzb_en_i  input  1  leading-zero blanking enable; sampled each cycle.
nibble_o  output  4  nibble to shared decoder input_i.
seg_i  input  8  decoder output_o (active-low segments, bit7 = dp).
seg_o  output  8  segment pins, active-low, registered.
an_o  output  NUM_DIGITS  anode enables, active-low, registered.
frame_o  output  1  one-cycle pulse at each frame start (commit point).

Behaviour:
- Reset values (async on rst_i): an_o = all 1; seg_o = 8'hFF; nibble_o = 0; load_ready_o = 1; frame_o = 0; display register = 0; shadow register = 0; pending flag = 0; digit index = 0; slot counter = 0; state = BLANK.
- Reset mid-operation: everything returns to these values immediately, and any pending shadow word is discarded.
- FSM states:
  - BLANK: lasts BLANK_CYCLES cycles; an_o = all 1; seg_o = 8'hFF.
  - SHOW: lasts PRESCALE - BLANK_CYCLES cycles.
  - Transitions: BLANK -> SHOW when the slot counter reaches BLANK_CYCLES-1. SHOW -> BLANK when the counter reaches PRESCALE-1; at that point the counter clears and the index increments.
  - Index wrap: the index wraps NUM_DIGITS-1 -> 0.
- Slot timing: on the first BLANK cycle of every slot, nibble_o <= display[4*idx +: 4]. nibble_o is stable for the rest of the slot, so the decoder is settled before SHOW.
- SHOW outputs, per cycle:
  - seg_o <= seg_i.
  - an_o <= ~(1 << idx), unless the digit is blanked; a blanked digit gives an_o = all 1 and seg_o = 8'hFF.
- Leading-zero blanking: when lzb_en_i = 1, digit i (i >= 1) is blanked iff digits i..NUM_DIGITS-1 of the display register are all 4'h0. Digit 0 is never blanked.
- Frame boundary: the first cycle of digit 0's BLANK slot, including the first cycle out of reset.
  - frame_o = 1 for exactly that cycle.
  - If pending = 1, display <= shadow and pending <= 0 on that cycle.
- Load handshake:
  - load_ready_o = ~pending.
  - On valid && ready: shadow <= load_data_i, pending <= 1, and load_ready_o drops the next cycle.
  - A word accepted on a frame-boundary cycle is NOT committed at that boundary; it waits for the next one.
  - Only one word can be outstanding; further valids stall until after the commit. ready rises the cycle after commit.
- Frame length: NUM_DIGITS*PRESCALE cycles. The worst-case load-to-display latency is < 2 frames.
- Widths: counter = $clog2(PRESCALE) bits; index = max(1, $clog2(NUM_DIGITS)) bits. No arithmetic on data; nibbles are passed unmodified (decode of A-F is the decoder's responsibility).

Test Plan:
- Reset, NUM_DIGITS=4, PRESCALE=16, BLANK_CYCLES=2: deassert rst_i -> frame_o pulses cycle 0 and every 64 cycles; an_o steps 1110,1101,1011,0111 in SHOW windows of 14 cycles, each preceded by 2 cycles of an_o=1111, seg_o=FF; load_ready_o=1.
- Load 16'h1234, lzb off, decoder connected -> after next frame_o, digit0 slot nibble_o=4, seg_o=99; digit3 slot nibble_o=1, seg_o=F9; load_ready_o low from the accept cycle until 1 cycle after the commit.
- Load 16'h0070 with lzb_en_i=1 -> digits 3,2 keep an_o=1111/seg_o=FF in their slots; digits 1,0 show 7 (F8) and 0 (C0); load 16'h0000 -> only digit 0 lit (C0).
- Back-to-back: load 16'hAAAA then hold valid with 16'h5555 -> second word is accepted only after the commit of the first; display shows AAAA for at least one full frame, then 5555.
- Load accepted exactly on a frame_o cycle -> the display is unchanged at that frame and updates at the following frame_o.
- Assert rst_i mid-SHOW of digit 2 with a pending word -> outputs go to reset values asynchronously; after release the display is 0 and the pending word is lost (load_ready_o=1).
